// File: rtl/sr_ff_bank.sv
// sr_ff_bank: bank of clocked SR flags with configurable s=r=1 resolution and conflict tracking (counter under SR_FF_BANK_CONFLICT_CNT_EN)
module sr_ff_bank #(
    parameter int                 WIDTH   = 8,
    parameter int                 MODE    = 0,
    parameter int                 CNT_W   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_conflict,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);
    if (MODE < 0 || MODE > 3) begin : g_bad_mode
        $error("sr_ff_bank: MODE %0d is not one of 0..3", MODE);
    end

    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] q_nxt;
    logic             any;

    // next q: plain set/reset/hold, with s=r=1 channels resolved by MODE
    always_comb begin
        both  = s & r;
        res   = MODE == 0 ? '0 : MODE == 1 ? '1 : MODE == 2 ? q : ~q;
        q_nxt = (s & ~r) | (q & ~(s | r)) | (both & res);
        any   = en & |both;
    end

    // q and its complement held in separate registers so qn never lags q
    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= RST_VAL;
            qn <= ~RST_VAL;
        end else if (en) begin
            q  <= q_nxt;
            qn <= ~q_nxt;
        end
    end

    // sticky conflict flags; a fresh conflict beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst)
            conflict <= '0;
        else if (en)
            conflict <= (clr_conflict ? '0 : conflict) | both;
    end

`ifdef SR_FF_BANK_CONFLICT_CNT_EN
    // saturating count of cycles with at least one conflicting channel
    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= '0;
        else if (en)
            conflict_cnt <= clr_conflict ? (any ? CNT_W'(1) : '0)
                          : (any && conflict_cnt != {CNT_W{1'b1}}) ? conflict_cnt + CNT_W'(1)
                          : conflict_cnt;
    end
`else
    assign conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank: directed checks of sr_ff_bank across all four conflict modes
module tb_sr_ff_bank;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] s;
    logic [7:0] r;
    logic       clr_conflict;
    logic [7:0] q_o   [4];
    logic [7:0] qn_o  [4];
    logic [7:0] cf_o  [4];
    logic [3:0] cnt_o [4];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sr_ff_bank #(.WIDTH(8), .MODE(g), .CNT_W(4), .RST_VAL(8'hA5)) u_dut (
            .clk(clk),
            .rst(rst),
            .en(en),
            .s(s),
            .r(r),
            .clr_conflict(clr_conflict),
            .q(q_o[g]),
            .qn(qn_o[g]),
            .conflict(cf_o[g]),
            .conflict_cnt(cnt_o[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input logic [7:0] e3,
                       input logic [7:0] ecf, input logic [3:0] ecnt_on);
        logic [7:0] eq [4];
        logic [3:0] ecnt;
        eq[0] = e0;
        eq[1] = e1;
        eq[2] = e2;
        eq[3] = e3;
`ifdef SR_FF_BANK_CONFLICT_CNT_EN
        ecnt = ecnt_on;
`else
        ecnt = 4'd0;
`endif
        for (int m = 0; m < 4; m++) begin
            tests++;
            assert (q_o[m] === eq[m]) else begin
                fails++;
                $error("FAIL %s q mode%0d got %h expected %h", tag, m, q_o[m], eq[m]);
            end
            tests++;
            assert (qn_o[m] === ~eq[m]) else begin
                fails++;
                $error("FAIL %s qn mode%0d got %h expected %h", tag, m, qn_o[m], ~eq[m]);
            end
            tests++;
            assert (cf_o[m] === ecf) else begin
                fails++;
                $error("FAIL %s conflict mode%0d got %h expected %h", tag, m, cf_o[m], ecf);
            end
            tests++;
            assert (cnt_o[m] === ecnt) else begin
                fails++;
                $error("FAIL %s conflict_cnt mode%0d got %0d expected %0d", tag, m, cnt_o[m], ecnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; s = 8'hFF; r = 8'h00; clr_conflict = 1'b1;
        tick();
        tick();
        chk("reset", 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
        rst = 1'b0; clr_conflict = 1'b0; s = 8'h00; r = 8'hFF;
        tick();
        chk("clear_all", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0);
        s = 8'h0F; r = 8'hF0;
        tick();
        chk("set_reset", 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00, 4'd0);
        s = 8'h00; r = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        chk("hold", 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00, 4'd0);
        s = 8'h01; r = 8'hFE;
        tick();
        chk("load_01", 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 4'd0);
        s = 8'h03; r = 8'h03;
        tick();
        chk("conflict_modes", 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 4'd1);
        en = 1'b0; s = 8'hFF; r = 8'hFF;
        for (int i = 0; i < 5; i++) tick();
        chk("en_gating", 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 4'd1);
        en = 1'b1; s = 8'h00; r = 8'h00; clr_conflict = 1'b1;
        tick();
        chk("clr", 8'h00, 8'h03, 8'h01, 8'h02, 8'h00, 4'd0);
        clr_conflict = 1'b0; s = 8'h01; r = 8'h01;
        for (int i = 0; i < 14; i++) tick();
        chk("cnt_14", 8'h00, 8'h03, 8'h01, 8'h02, 8'h01, 4'd14);
        tick();
        chk("cnt_15", 8'h00, 8'h03, 8'h01, 8'h03, 8'h01, 4'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("cnt_sat", 8'h00, 8'h03, 8'h01, 8'h02, 8'h01, 4'd15);
        s = 8'h00; r = 8'h00; clr_conflict = 1'b1;
        tick();
        chk("clr_sat", 8'h00, 8'h03, 8'h01, 8'h02, 8'h00, 4'd0);
        s = 8'h04; r = 8'h04;
        tick();
        chk("clr_vs_conflict", 8'h00, 8'h07, 8'h01, 8'h06, 8'h04, 4'd1);
        clr_conflict = 1'b0; rst = 1'b1; s = 8'hFF; r = 8'h00;
        tick();
        chk("mid_reset", 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
        rst = 1'b0; s = 8'h00; r = 8'h00;
        tick();
        chk("post_reset_hold", 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
